// File: rtl/register.sv
// register: 32 x 32 general-purpose register file for the MIPS-style datapath, r0 hardwired to zero.
// Latency: reads are combinational (0 cycles) with write-through bypass; writes commit on rising clk.
// Backpressure: none; a write is accepted every cycle that regwrite=1.
//
// Ports:
//   clk        rising-edge clock for all register updates
//   rst        asynchronous active-high reset; clears every register and forces A/B to 0
//   rs, rt     read selects for ports A and B
//   rd         write select; writes to r0 are discarded
//   writedata  value stored verbatim into reg[rd] when regwrite=1
//   regwrite   write enable, sampled on the rising edge of clk
//   A, B       contents of reg[rs] / reg[rt], or writedata when bypassing an in-flight write
module register #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32   // must equal 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic                  regwrite,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // A write is only committed when the enable and a nonzero select are both
  // known-true; an unknown rd or regwrite makes the condition non-true and the
  // write is dropped.
  logic write_en;
  assign write_en = regwrite && (rd != '0);

  // r0 is never written, so after reset it reads zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[rd] <= writedata;
    end
  end

  // Read ports. Reset forces zero (and kills the bypass); rs/rt of 0 read zero
  // without depending on storage; a matching in-flight write is forwarded so the
  // decode stage sees the value that will be architecturally visible after the edge.
  always_comb begin
    A = '0;
    if (!rst && (rs != '0)) begin
      if (write_en && (rd == rs)) begin
        A = writedata;
      end else begin
        A = mem[rs];
      end
    end
  end

  always_comb begin
    B = '0;
    if (!rst && (rt != '0)) begin
      if (write_en && (rd == rt)) begin
        B = writedata;
      end else begin
        B = mem[rt];
      end
    end
  end

endmodule

// File: tb/tb_register.sv
// tb_register: directed self-checking bench for the register file.
// Inputs change a little after clock edges; outputs are sampled #1 after each input change.
// Expected values are hand-computed constants for each step.
module tb_register;

  logic        clk;
  logic        rst;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        regwrite;
  logic [31:0] A;
  logic [31:0] B;

  int compared;
  int mismatched;

  register #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .writedata(writedata),
    .regwrite (regwrite),
    .A        (A),
    .B        (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    rs         = '0;
    rt         = '0;
    rd         = '0;
    writedata  = '0;
    regwrite   = 1'b0;

    // Reset held for two cycles, released between edges.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Every address reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(31 - i);
      #1;
      check($sformatf("reset_A_r%0d", i), A, 32'h0);
      check($sformatf("reset_B_r%0d", 31 - i), B, 32'h0);
    end

    // Basic write r3 <= 100.
    rd = 5'd3; writedata = 32'd100; regwrite = 1'b1;
    @(posedge clk); #1;
    regwrite = 1'b0;
    rs = 5'd2; rt = 5'd3; #1;
    check("basic_A_r2", A, 32'd0);
    check("basic_B_r3", B, 32'd100);
    rs = 5'd4; rt = 5'd5; #1;
    check("basic_A_r4", A, 32'd0);
    check("basic_B_r5", B, 32'd0);

    // Second write r6 <= 100 with bypass on A before the edge.
    rd = 5'd6; writedata = 32'd100; regwrite = 1'b1; rs = 5'd6; #1;
    check("bypass_A_r6_pre", A, 32'd100);
    @(posedge clk); #1;
    regwrite = 1'b0; #1;
    check("stored_A_r6", A, 32'd100);
    rt = 5'd3; #1;
    check("indep_B_r3", B, 32'd100);

    // Bypass with a value that differs from the stored one, on both ports.
    rd = 5'd6; writedata = 32'h0000_0037; regwrite = 1'b1; rs = 5'd6; rt = 5'd6; #1;
    check("bypass_A_r6_new", A, 32'h0000_0037);
    check("bypass_B_r6_new", B, 32'h0000_0037);
    regwrite = 1'b0; #1;
    check("nobypass_A_r6_old", A, 32'd100);
    rd = 5'd9; writedata = 32'd123; regwrite = 1'b1; rt = 5'd9; #1;
    check("bypass_B_r9_pre", B, 32'd123);
    check("nobypass_A_r6", A, 32'd100);
    @(posedge clk); #1;
    regwrite = 1'b0; #1;
    check("stored_B_r9", B, 32'd123);

    // Writes to r0 are discarded, including during the write cycle.
    rd = 5'd0; writedata = 32'hDEAD_BEEF; regwrite = 1'b1; rs = 5'd0; rt = 5'd0; #1;
    check("zero_A_during", A, 32'h0);
    check("zero_B_during", B, 32'h0);
    @(posedge clk); #1;
    regwrite = 1'b0; #1;
    check("zero_A_after", A, 32'h0);
    check("zero_B_after", B, 32'h0);

    // Write-disable keeps r3, then overwrite with all ones.
    regwrite = 1'b0; rd = 5'd3; writedata = 32'd7; rt = 5'd3; #1;
    @(posedge clk); #1;
    check("wdis_B_r3", B, 32'd100);
    regwrite = 1'b1; writedata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    regwrite = 1'b0; #1;
    check("overwrite_B_r3", B, 32'hFFFF_FFFF);
    rs = 5'd3; #1;
    check("same_sel_A_r3", A, 32'hFFFF_FFFF);

    // rs==rt==rd with a write in flight: both ports see writedata.
    rd = 5'd3; writedata = 32'h1234_5678; regwrite = 1'b1; #1;
    check("triple_A", A, 32'h1234_5678);
    check("triple_B", B, 32'h1234_5678);
    @(posedge clk); #1;
    regwrite = 1'b0; #1;
    check("triple_A_stored", A, 32'h1234_5678);

    // Async reset between edges clears outputs immediately.
    rs = 5'd3; rt = 5'd6; #1;
    check("pre_rst_A_r3", A, 32'h1234_5678);
    check("pre_rst_B_r6", B, 32'd100);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("async_rst_A", A, 32'h0);
    check("async_rst_B", B, 32'h0);

    // Write and bypass suppressed while reset is high.
    rd = 5'd6; writedata = 32'd77; regwrite = 1'b1; rs = 5'd6; #1;
    check("rst_bypass_A", A, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    regwrite = 1'b0; rst = 1'b0; #1;
    check("post_rst_A_r6", A, 32'h0);
    rt = 5'd3; #1;
    check("post_rst_B_r3", B, 32'h0);
    rs = 5'd9; #1;
    check("post_rst_A_r9", A, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
